adder_32: RTL and testbench
===========================

// Module: adder_32
// PURPOSE
//  Registered IEEE-754 single-precision floating-point adder: Sum = A + B.
//  Operands and result are raw 32-bit binary32 words (sign[31], exp[30:23], frac[22:0]).
//  Single-cycle-latency arithmetic unit, one result per clock; used as the FP add stage of the datapath.
// PARAMETERS
//  none (format fixed at binary32)
// PORTS
//  clk        in   1   system clock; all state updates on rising edge
//  rst_n      in   1   synchronous reset, active low
//  in_valid   in   1   A/B valid this cycle; sampled on rising edge
//  A          in   32  operand A, binary32
//  B          in   32  operand B, binary32
//  Sum        out  32  registered result A+B, binary32
//  out_valid  out  1   Sum holds the result of the operands accepted on the previous edge
// BEHAVIOUR
//  - One clock domain (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
//  - Reset: Sum=32'h0000_0000, out_valid=0. Reset wins over in_valid on the same edge; an in-flight op is discarded.
//  - Latency 1: on edge with in_valid=1, Sum<=f(A,B), out_valid<=1.
//  - in_valid=0: Sum holds its previous value, out_valid<=0. No backpressure; accepts every cycle.
//  - Datapath (combinational before the register):
//    1. Unpack; hidden bit=1 for exp!=0. Subnormal inputs (exp=0) are flushed to signed zero.
//    2. Order operands by magnitude ({exp,frac}); diff = expL - expS.
//    3. Align smaller significand right by diff. Keep guard, round, sticky (OR of all shifted-out bits).
//       diff>=26: smaller operand contributes sticky only.
//    4. Same signs: add significands. 1-bit carry-out -> shift right 1, exp+1, sticky absorbs lost bit.
//       Different signs: subtract smaller from larger. Leading-zero count -> normalise left, exp-=lzc.
//    5. Round to nearest, ties to even, using guard/round/sticky.
//       Rounding carry-out -> renormalise, exp+1.
//    6. Result sign = sign of larger-magnitude operand.
//  - Boundaries:
//    - Exact zero from cancellation (x + -x) -> +0 (32'h0000_0000).
//    - (+0)+(+0) -> +0; (-0)+(-0) -> -0; (+0)+(-0) -> +0.
//    - Zero plus x -> x (after flush of subnormal x).
//    - Final exp>=255 -> overflow -> signed infinity (exp=FF, frac=0).
//    - Final exp<=0 -> underflow -> signed zero (flush-to-zero; no subnormal outputs).
//    - Any NaN input (exp=FF, frac!=0) -> canonical qNaN 32'h7FC0_0000.
//    - Inf + finite -> that Inf. Inf + same-sign Inf -> Inf. +Inf + -Inf -> 32'h7FC0_0000.
//  - No exception flags; fully synchronous; no multicycle paths.
// TESTING
//  T1 A=3E80_0000 (0.25), B=42C8_0000 (100.0), in_valid=1
//     -> next edge Sum=42C8_8000 (100.25), out_valid=1.
//  T2 A=550C_0000, B=0F80_0084 (exponent gap >26)
//     -> Sum=550C_0000 (small operand absorbed, sticky only).
//  T3 Rounding/cancellation:
//     - 3F80_0000 + 3380_0000 -> 3F80_0000 (tie to even).
//     - 3F80_0000 + 33C0_0000 -> 3F80_0001 (rounds up).
//     - 3F80_0000 + BF80_0000 -> 0000_0000.
//     - 4040_0000 + BF80_0000 -> 4000_0000 (3-1=2).
//  T4 Overflow/specials:
//     - 7F7F_FFFF + 7F7F_FFFF -> 7F80_0000.
//     - 7F80_0000 + FF80_0000 -> 7FC0_0000.
//     - 7FA0_0000 + 3F80_0000 -> 7FC0_0000.
//     - 0040_0000 + 0000_0000 -> 0000_0000 (FTZ).
//  T5 Back-to-back ops on consecutive edges -> each result one cycle later, no bubbles.
//     in_valid=0 -> out_valid=0, Sum held.
//  T6 rst_n=0 on the same edge as in_valid=1 -> Sum=0, out_valid=0.
//     Releasing rst_n resumes normal operation on the next accepted op.

Source files
------------

// File: rtl/adder_32.sv
// adder_32: registered binary32 floating-point adder, round-to-nearest-even, flush-to-zero
module adder_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum,
  output logic        out_valid
);
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, s_l, s_s, rnd;
  logic [7:0]  e_l, e_s, diff;
  logic [23:0] m_l, m_s;
  logic [49:0] sh;
  logic [26:0] x_l, x_s, n;
  logic [27:0] t;
  logic [4:0]  lz;
  logic [9:0]  e_n, e_f;
  logic [24:0] m_r;
  logic [31:0] arith, res;
  always_comb begin
    a_zero = A[30:23] == 8'h00;
    b_zero = B[30:23] == 8'h00;
    a_inf  = A[30:23] == 8'hFF && A[22:0] == 23'b0;
    b_inf  = B[30:23] == 8'hFF && B[22:0] == 23'b0;
    a_nan  = A[30:23] == 8'hFF && A[22:0] != 23'b0;
    b_nan  = B[30:23] == 8'hFF && B[22:0] != 23'b0;
    swap   = B[30:0] > A[30:0];
    {s_l, e_l, m_l} = swap ? {B[31], B[30:23], 1'b1, B[22:0]} : {A[31], A[30:23], 1'b1, A[22:0]};
    {s_s, e_s, m_s} = swap ? {A[31], A[30:23], 1'b1, A[22:0]} : {B[31], B[30:23], 1'b1, B[22:0]};
    diff = e_l - e_s;
    // past 26 the small operand only ever lands in sticky, so clamp the shift
    sh   = {m_s, 26'b0} >> (diff > 8'd26 ? 8'd26 : diff);
    x_l  = {m_l, 3'b000};
    x_s  = {sh[49:26], sh[25], sh[24], |sh[23:0]};
    t    = (s_l ^ s_s) ? {1'b0, x_l} - {1'b0, x_s} : {1'b0, x_l} + {1'b0, x_s};
    lz   = 5'd0;
    for (int i = 0; i < 27; i++)
      if (t[i]) lz = 5'(26 - i);
    n    = t[27] ? {t[27:2], t[1] | t[0]} : t[26:0] << lz;
    e_n  = {2'b0, e_l} + {9'b0, t[27]} - {5'b0, lz};
    rnd  = n[2] & (n[1] | n[0] | n[3]);
    m_r  = {1'b0, n[26:3]} + {24'b0, rnd};
    e_f  = e_n + {9'b0, m_r[24]};
    arith = t == 28'b0 ? 32'h0000_0000 :
            (e_f[9] || e_f == 10'd0) ? {s_l, 31'b0} :
            e_f >= 10'd255 ? {s_l, 8'hFF, 23'b0} : {s_l, e_f[7:0], m_r[22:0]};
    res = (a_nan || b_nan || (a_inf && b_inf && (A[31] ^ B[31]))) ? 32'h7FC0_0000 :
          a_inf ? A : b_inf ? B :
          (a_zero && b_zero) ? {A[31] & B[31], 31'b0} :
          a_zero ? B : b_zero ? A : arith;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Sum <= res;
    end
  end
endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed scoreboard bench for the binary32 adder
module tb_adder_32;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic [31:0] A = 0, B = 0;
  logic [31:0] Sum;
  logic        out_valid;
  int          total = 0, bad = 0;
  logic [31:0] sb [$];
  logic [31:0] last = 0;
  adder_32 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .Sum(Sum), .out_valid(out_valid));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 32'h1, 32'h0);
      else begin
        last = sb.pop_front();
        chk("sum", Sum, last);
      end
    end
  end
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    A = a; B = b; in_valid = 1;
    sb.push_back(exp);
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sum", Sum, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1;
    op(32'h3E80_0000, 32'h42C8_0000, 32'h42C8_8000);
    op(32'h550C_0000, 32'h0F80_0084, 32'h550C_0000);
    op(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    op(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
    op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    op(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000);
    op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    op(32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    op(32'h0040_0000, 32'h0000_0000, 32'h0000_0000);
    op(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    op(32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    op(32'h0000_0000, 32'hC049_0FDB, 32'hC049_0FDB);
    op(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
    op(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);
    op(32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000);
    op(32'h3F7F_FFFF, 32'h3380_0000, 32'h3F80_0000);
    op(32'h3F7F_FFFF, 32'h3300_0000, 32'h3F80_0000);
    op(32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
    op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    idle();
    @(negedge clk);
    chk("idle_valid", {31'b0, out_valid}, 32'h0);
    chk("idle_hold", Sum, 32'h4080_0000);
    op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk);
    rst_n = 0; A = 32'h4040_0000; B = 32'h4040_0000; in_valid = 1;
    @(negedge clk);
    chk("rst_wins_sum", Sum, 32'h0);
    chk("rst_wins_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1; in_valid = 0;
    op(32'hC080_0000, 32'h3F80_0000, 32'hC040_0000);
    idle();
    @(negedge clk);
    chk("queue_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
